snowball_memresp: RTL and testbench
===================================

SNOWBALL_MEMRESP -- requirements
Module: snowball_memresp

Interface
REQ-001 Parameter ADDR_BITS, default 9, SHALL set backing-store depth to 2^ADDR_BITS 32-bit words, indexed by mem_addr[ADDR_BITS-1:0].
REQ-002 Parameter ACK_DELAY, default 2 (legal 1..7), SHALL set the cycles from request acceptance to mem_ack.
REQ-003 Parameter READ_LATENCY, default 4 (legal 2..7), SHALL set the cycles from the mem_ack cycle to read word 0.
REQ-004 MCU_CLK  in  1  sole clock; all state on rising edge.
REQ-005 RST  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 mem_addr  in  32  request word address; bits above ADDR_BITS-1 ignored.
REQ-007 mem_we  in  1  1 = write request, 0 = read request.
REQ-008 mem_we_array  in  4  byte-lane write enables; bit3 -> [31:24], bit0 -> [7:0].
REQ-009 mem_do_act  in  1  request valid; held by requester until after it sees mem_ack.
REQ-010 mem_dataintomem  in  32  write data.
REQ-011 mem_ack  out  1  one-cycle acknowledge.
REQ-012 mem_datafrommem  out  32  read burst data; all-zero when no burst word is being driven.
REQ-013 resp_busy  out  1  high whenever state is not IDLE.
REQ-014 proto_err  out  1  sticky protocol-violation flag.

Function
REQ-015 FSM states SHALL be IDLE, DELAY, ACK, DRAIN.
REQ-016 In IDLE with mem_do_act=1 at edge k, the block SHALL latch mem_addr, mem_we, mem_we_array, mem_dataintomem and enter DELAY (acceptance at edge k).
REQ-017 mem_ack SHALL be 1 for exactly the one cycle beginning at edge k+ACK_DELAY (state ACK); 0 at all other times.
REQ-018 A write SHALL commit the latched byte lanes at edge k+ACK_DELAY+1; unmasked lanes unchanged; mem_we_array=0000 commits nothing but is still acknowledged.
REQ-019 A read SHALL drive word at latched index on mem_datafrommem during the cycle beginning at edge k+ACK_DELAY+READ_LATENCY, then the word at index with bit0 inverted during the next cycle, then zero.
REQ-020 Read data SHALL reflect all writes committed before the read's acceptance edge.
REQ-021 After ACK the FSM SHALL enter DRAIN and return to IDLE only when mem_do_act=0 and any read burst has fully completed.
REQ-022 mem_do_act high in DRAIN SHALL NOT be treated as a new request; a new request SHALL be accepted no earlier than the edge following DRAIN->IDLE.
REQ-023 If mem_do_act falls while in DELAY, the block SHALL abort (no write commit, no ack, no burst), set proto_err, return to IDLE.
REQ-024 Latched request fields SHALL NOT change between acceptance and DRAIN->IDLE regardless of input activity.
REQ-025 ACK_DELAY/READ_LATENCY counters SHALL be 3 bits wide and SHALL NOT wrap within one transaction.
REQ-026 proto_err SHALL clear only on reset.

Reset
REQ-027 RST=0 SHALL immediately force state IDLE, mem_ack=0, mem_datafrommem=0, resp_busy=0, proto_err=0, and cancel any pending write or burst.
REQ-028 Backing-store contents SHALL NOT be reset; reset mid-write SHALL leave the target word either fully old or fully new.
REQ-029 After RST rises, the first edge with mem_do_act=1 SHALL be accepted as a new request.

Verification
REQ-030 Write 0xDEADBEEF to addr 0x10, lanes 1111, accepted edge k -> mem_ack high cycle k+2 only; read of 0x10 later returns 0xDEADBEEF at ack+4.
REQ-031 Preload 0x10=0x11111111, 0x11=0x22222222; read addr 0x11 -> 0x22222222 at ack+4, 0x11111111 at ack+5, zero at ack+6.
REQ-032 0x20=0xAABBCCDD, write 0x00001234 lanes 1100 -> read 0x20 returns 0x0000CCDD.
REQ-033 Hold mem_do_act high 3 cycles past ack -> no second ack, no second burst; resp_busy drops only after mem_do_act=0.
REQ-034 Drop mem_do_act one cycle after acceptance of write 0x5 -> no ack, proto_err=1, addr 0x5 unchanged.
REQ-035 Assert RST=0 during read burst word 0 -> mem_datafrommem=0 immediately, no word 1; next request after release completes normally.

Source files
------------

// File: rtl/snowball_memresp.sv
// snowball_memresp: single-port memory responder with delayed acknowledge
// and a two-word read burst (requested word, then its bit0-flipped neighbour).
//
// Handshake: the requester raises mem_do_act with stable request fields and
// keeps it high until it has seen the one-cycle mem_ack. The request is
// captured on the first IDLE edge where mem_do_act is high. After the ack the
// block waits in DRAIN until mem_do_act is low and any read burst has
// finished, so a held-high mem_do_act is never taken as a second request.
module snowball_memresp #(
    parameter int ADDR_BITS    = 9,
    parameter int ACK_DELAY    = 2,
    parameter int READ_LATENCY = 4
) (
    input  logic        MCU_CLK,
    input  logic        RST,
    input  logic [31:0] mem_addr,
    input  logic        mem_we,
    input  logic [3:0]  mem_we_array,
    input  logic        mem_do_act,
    input  logic [31:0] mem_dataintomem,
    output logic        mem_ack,
    output logic [31:0] mem_datafrommem,
    output logic        resp_busy,
    output logic        proto_err,
    output logic [1:0]  fsm_state_o
);

    typedef enum logic [1:0] {S_IDLE, S_DELAY, S_ACK, S_DRAIN} state_t;
    typedef enum logic [1:0] {B_WAIT, B_W0, B_W1, B_DONE} burst_t;

    localparam logic [2:0] ACK_CNT = 3'(ACK_DELAY);
    localparam logic [2:0] RD_CNT  = 3'(READ_LATENCY);

    state_t                 state_q;
    burst_t                 phase_q;
    logic [2:0]             cnt_q;
    logic                   ack_q;
    logic                   err_q;
    logic [31:0]            dout_q;
    logic [ADDR_BITS-1:0]   addr_q;
    logic                   we_q;
    logic [3:0]             be_q;
    logic [31:0]            wdata_q;
    logic [31:0]            mem_q [2**ADDR_BITS];
    logic [ADDR_BITS-1:0]   addr_pair;
    logic                   unused_addr_bits;

    // Upper address bits are don't-care; second burst word is the bit0 partner.
    assign unused_addr_bits = ^mem_addr[31:ADDR_BITS];
    assign addr_pair        = {addr_q[ADDR_BITS-1:1], ~addr_q[0]};

    assign mem_ack         = ack_q;
    assign mem_datafrommem = dout_q;
    assign proto_err       = err_q;
    assign resp_busy       = (state_q != S_IDLE);
    assign fsm_state_o     = state_q;

    // Request FSM: capture, ack delay, burst sequencing and protocol checking.
    always_ff @(posedge MCU_CLK or negedge RST) begin
        if (!RST) begin
            state_q <= S_IDLE;
            phase_q <= B_DONE;
            cnt_q   <= 3'd0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dout_q  <= 32'd0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
        end else begin
            ack_q  <= 1'b0;
            dout_q <= 32'd0;
            case (state_q)
                S_IDLE: begin
                    if (mem_do_act) begin
                        addr_q  <= mem_addr[ADDR_BITS-1:0];
                        we_q    <= mem_we;
                        be_q    <= mem_we_array;
                        wdata_q <= mem_dataintomem;
                        cnt_q   <= 3'd1;
                        state_q <= S_DELAY;
                    end
                end
                S_DELAY: begin
                    // Requester gave up before the ack: drop everything, flag it.
                    if (!mem_do_act) begin
                        err_q   <= 1'b1;
                        state_q <= S_IDLE;
                    end else if (cnt_q == ACK_CNT) begin
                        ack_q   <= 1'b1;
                        cnt_q   <= 3'd1;
                        state_q <= S_ACK;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                S_ACK: begin
                    // cnt_q counts edges since the ack edge; it saturates at RD_CNT.
                    cnt_q   <= cnt_q + 3'd1;
                    phase_q <= we_q ? B_DONE : B_WAIT;
                    state_q <= S_DRAIN;
                end
                S_DRAIN: begin
                    case (phase_q)
                        B_WAIT: begin
                            if (cnt_q == RD_CNT) begin
                                dout_q  <= mem_q[addr_q];
                                phase_q <= B_W0;
                            end else begin
                                cnt_q <= cnt_q + 3'd1;
                            end
                        end
                        B_W0: begin
                            dout_q  <= mem_q[addr_pair];
                            phase_q <= B_W1;
                        end
                        default: begin
                            phase_q <= B_DONE;
                            if (!mem_do_act) begin
                                state_q <= S_IDLE;
                            end
                        end
                    endcase
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Backing store, never reset; a write commits on the edge that leaves ACK.
    always_ff @(posedge MCU_CLK) begin
        if (state_q == S_ACK && we_q) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) begin
                    mem_q[addr_q][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_snowball_memresp.sv
// Directed bench for snowball_memresp: driver tasks issue requests and push
// expected burst data; an independent monitor pops on every mem_ack.
module tb_snowball_memresp;

    localparam int AD = 2;
    localparam int RL = 4;

    logic        MCU_CLK;
    logic        RST;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_we_array;
    logic        mem_do_act;
    logic [31:0] mem_dataintomem;
    logic        mem_ack;
    logic [31:0] mem_datafrommem;
    logic        resp_busy;
    logic        proto_err;
    logic [1:0]  fsm_state_o;

    // {is_read, word0, word1}
    logic [64:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    snowball_memresp #(.ADDR_BITS(9), .ACK_DELAY(AD), .READ_LATENCY(RL)) dut (
        .MCU_CLK(MCU_CLK),
        .RST(RST),
        .mem_addr(mem_addr),
        .mem_we(mem_we),
        .mem_we_array(mem_we_array),
        .mem_do_act(mem_do_act),
        .mem_dataintomem(mem_dataintomem),
        .mem_ack(mem_ack),
        .mem_datafrommem(mem_datafrommem),
        .resp_busy(resp_busy),
        .proto_err(proto_err),
        .fsm_state_o(fsm_state_o)
    );

    // Clock and global time limit
    initial begin
        MCU_CLK = 1'b0;
        forever #5 MCU_CLK = ~MCU_CLK;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish (checks %0d errors %0d)", checks, errors);
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge; returns at a negedge with the DUT idle.
    task automatic wait_idle(input string tag);
        for (int i = 0; i < 40; i++) begin
            if (resp_busy === 1'b0) break;
            @(negedge MCU_CLK);
        end
        chk({tag, "_idle"}, 32'(resp_busy), 32'd0);
    endtask

    // One complete request; hold = extra cycles mem_do_act stays high after ack.
    task automatic xact(input string tag, input logic [31:0] addr, input logic we,
                        input logic [3:0] be, input logic [31:0] data, input int hold,
                        input logic [31:0] w0, input logic [31:0] w1);
        wait_idle(tag);
        mem_addr        = addr;
        mem_we          = we;
        mem_we_array    = be;
        mem_dataintomem = data;
        mem_do_act      = 1'b1;
        exp_q.push_back({~we, w0, w1});
        @(posedge MCU_CLK);
        for (int j = 0; j <= AD; j++) begin
            @(negedge MCU_CLK);
            chk({tag, "_ack"}, 32'(mem_ack), (j == AD) ? 32'd1 : 32'd0);
        end
        for (int h = 1; h <= hold; h++) begin
            mem_addr        = $urandom;
            mem_we          = 1'($urandom_range(0, 1));
            mem_we_array    = 4'($urandom_range(0, 15));
            mem_dataintomem = $urandom;
            @(negedge MCU_CLK);
            chk({tag, "_hold_busy"}, 32'(resp_busy), 32'd1);
            chk({tag, "_hold_noack"}, 32'(mem_ack), 32'd0);
        end
        mem_do_act      = 1'b0;
        mem_addr        = $urandom;
        mem_dataintomem = $urandom;
        mem_we_array    = 4'($urandom_range(0, 15));
        @(negedge MCU_CLK);
        chk({tag, "_ack_low"}, 32'(mem_ack), 32'd0);
    endtask

    // Scoreboard monitor: every ack pops one expected entry; reads check the burst.
    initial begin
        logic [64:0] e;
        forever begin
            @(negedge MCU_CLK);
            if (mem_ack === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: got ack with empty queue at %0t, expected none", $time);
                end else begin
                    e = exp_q.pop_front();
                    if (e[64]) begin
                        repeat (RL) @(negedge MCU_CLK);
                        chk("rd_word0", mem_datafrommem, e[63:32]);
                        @(negedge MCU_CLK);
                        chk("rd_word1", mem_datafrommem, e[31:0]);
                        @(negedge MCU_CLK);
                        chk("rd_tail_zero", mem_datafrommem, 32'd0);
                    end
                end
            end
        end
    end

    // Directed stimulus
    initial begin
        RST             = 1'b0;
        mem_addr        = 32'd0;
        mem_we          = 1'b0;
        mem_we_array    = 4'd0;
        mem_do_act      = 1'b0;
        mem_dataintomem = 32'd0;
        repeat (3) @(negedge MCU_CLK);
        chk("rst_ack", 32'(mem_ack), 32'd0);
        chk("rst_dout", mem_datafrommem, 32'd0);
        chk("rst_busy", 32'(resp_busy), 32'd0);
        chk("rst_err", 32'(proto_err), 32'd0);
        chk("rst_state", 32'(fsm_state_o), 32'd0);
        RST = 1'b1;
        @(negedge MCU_CLK);

        // Basic write then read-back; upper address bits must be ignored
        xact("wr11", 32'h0000_0011, 1'b1, 4'hF, 32'h2222_2222, 0, 32'd0, 32'd0);
        xact("wr10", 32'hFFFF_FE10, 1'b1, 4'hF, 32'hDEAD_BEEF, 0, 32'd0, 32'd0);
        xact("rd10", 32'h0000_0010, 1'b0, 4'h0, 32'd0, 0, 32'hDEAD_BEEF, 32'h2222_2222);

        // Burst order: requested word, then bit0 partner
        xact("wr10b", 32'h0000_0010, 1'b1, 4'hF, 32'h1111_1111, 0, 32'd0, 32'd0);
        xact("rd11", 32'h0000_0011, 1'b0, 4'h0, 32'd0, 0, 32'h2222_2222, 32'h1111_1111);

        // Byte-lane masking and the empty mask
        xact("wr20", 32'h0000_0020, 1'b1, 4'hF, 32'hAABB_CCDD, 0, 32'd0, 32'd0);
        xact("wr21", 32'h0000_0021, 1'b1, 4'hF, 32'h0BAD_F00D, 0, 32'd0, 32'd0);
        xact("wr20m", 32'h0000_0020, 1'b1, 4'hC, 32'h0000_1234, 0, 32'd0, 32'd0);
        xact("rd20", 32'h0000_0020, 1'b0, 4'h0, 32'd0, 0, 32'h0000_CCDD, 32'h0BAD_F00D);
        xact("wr21z", 32'h0000_0021, 1'b1, 4'h0, 32'hFFFF_FFFF, 0, 32'd0, 32'd0);
        xact("rd21", 32'h0000_0021, 1'b0, 4'h0, 32'd0, 0, 32'h0BAD_F00D, 32'h0000_CCDD);

        // mem_do_act held past ack: single ack, single burst
        xact("wr30", 32'h0000_0030, 1'b1, 4'hF, 32'h3030_3030, 3, 32'd0, 32'd0);
        xact("wr31", 32'h0000_0031, 1'b1, 4'hF, 32'h3131_3131, 0, 32'd0, 32'd0);
        xact("rd30h", 32'h0000_0030, 1'b0, 4'h0, 32'd0, 8, 32'h3030_3030, 32'h3131_3131);

        // Early drop of mem_do_act aborts the write and sets the sticky error
        xact("wr05", 32'h0000_0005, 1'b1, 4'hF, 32'h55AA_55AA, 0, 32'd0, 32'd0);
        xact("wr04", 32'h0000_0004, 1'b1, 4'hF, 32'h4444_4444, 0, 32'd0, 32'd0);
        wait_idle("abort");
        mem_addr        = 32'h0000_0005;
        mem_we          = 1'b1;
        mem_we_array    = 4'hF;
        mem_dataintomem = 32'hFFFF_FFFF;
        mem_do_act      = 1'b1;
        @(posedge MCU_CLK);
        @(negedge MCU_CLK);
        mem_do_act = 1'b0;
        @(negedge MCU_CLK);
        chk("abort_err", 32'(proto_err), 32'd1);
        chk("abort_busy", 32'(resp_busy), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("abort_noack", 32'(mem_ack), 32'd0);
            @(negedge MCU_CLK);
        end
        xact("rd05", 32'h0000_0005, 1'b0, 4'h0, 32'd0, 0, 32'h55AA_55AA, 32'h4444_4444);
        chk("err_sticky", 32'(proto_err), 32'd1);

        // Reset during burst word 0: output clears at once, word 1 never appears
        wait_idle("rstrd");
        mem_addr     = 32'h0000_0010;
        mem_we       = 1'b0;
        mem_we_array = 4'h0;
        mem_do_act   = 1'b1;
        exp_q.push_back({1'b1, 32'h1111_1111, 32'd0});
        @(posedge MCU_CLK);
        repeat (AD + RL + 1) @(negedge MCU_CLK);
        #1;
        RST        = 1'b0;
        mem_do_act = 1'b0;
        #1;
        chk("rstmid_dout", mem_datafrommem, 32'd0);
        chk("rstmid_ack", 32'(mem_ack), 32'd0);
        chk("rstmid_busy", 32'(resp_busy), 32'd0);
        chk("rstmid_err", 32'(proto_err), 32'd0);
        chk("rstmid_state", 32'(fsm_state_o), 32'd0);
        repeat (2) @(negedge MCU_CLK);
        RST = 1'b1;
        repeat (2) @(negedge MCU_CLK);
        xact("rd10r", 32'h0000_0010, 1'b0, 4'h0, 32'd0, 0, 32'h1111_1111, 32'h2222_2222);
        chk("err_after_rst", 32'(proto_err), 32'd0);

        // Let the monitor finish its last burst
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge MCU_CLK);
        end
        repeat (RL + 4) @(negedge MCU_CLK);
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
